// File: rtl/huil_volume_window_if.sv
// huil_volume_window_if
// DSP sample bus feeding the volume meter.
//   dsp_data  : DSP sample, SAMPLE_W bits
//   dsp_ready : ready level; each 0->1 transition presents one sample
// Modports: master = DSP side (drives), slave = meter side (receives).
interface huil_volume_window_if #(
    parameter int SAMPLE_W = 8
);
    logic [SAMPLE_W-1:0] dsp_data;
    logic                dsp_ready;

    modport master (output dsp_data, output dsp_ready);
    modport slave  (input  dsp_data, input  dsp_ready);
endinterface

// File: rtl/huil_volume_window.sv
// huil_volume_window
// Windowed cry-volume meter. Sums sample magnitudes between window ticks and
// publishes the scaled sum, the window peak, the sample count and a saturation
// flag. It also drives a debounced "loud" flag with on/off hysteresis.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   window_tick      : one-cycle strobe that closes the current window
//   dsp (slave)      : dsp_data / dsp_ready sample bus
//   volume           : acc[ACC_W-1 -: OUT_W] of the last closed window
//   peak             : largest magnitude in the last closed window
//   sample_count     : samples in the last closed window (saturating)
//   overflow         : accumulator saturated in the last closed window
//   volume_valid     : one-cycle pulse when the outputs above update
//   loud             : debounced loud indication
module huil_volume_window #(
    parameter int               SAMPLE_W     = 8,
    parameter int               SIGNED_IN    = 0,
    parameter int               ACC_W        = 14,
    parameter int               OUT_W        = 8,
    parameter int               CNT_W        = 8,
    parameter logic [OUT_W-1:0] THRESH_ON    = 8'h40,
    parameter logic [OUT_W-1:0] THRESH_OFF   = 8'h20,
    parameter int               LOUD_WINDOWS = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       window_tick,
    huil_volume_window_if.slave        dsp,
    output logic [OUT_W-1:0]           volume,
    output logic [SAMPLE_W-1:0]        peak,
    output logic [CNT_W-1:0]           sample_count,
    output logic                       overflow,
    output logic                       volume_valid,
    output logic                       loud
);

    localparam int RUN_W = $clog2(LOUD_WINDOWS + 1);

    typedef enum logic [1:0] {
        QUIET  = 2'd0,
        ARMING = 2'd1,
        LOUD   = 2'd2
    } loud_state_t;

    loud_state_t         state;
    logic [RUN_W-1:0]    run;

    logic                dsp_ready_q;
    logic [ACC_W-1:0]    acc;
    logic [CNT_W-1:0]    cnt;
    logic [SAMPLE_W-1:0] pk_w;
    logic                ovf_w;

    logic                sample_take;
    logic [SAMPLE_W-1:0] mag;
    logic [ACC_W-1:0]    acc_base;
    logic [ACC_W:0]      acc_sum;
    logic [ACC_W-1:0]    acc_next;
    logic                ovf_next;
    logic [CNT_W-1:0]    cnt_base;
    logic [CNT_W-1:0]    cnt_next;
    logic [SAMPLE_W-1:0] pk_base;
    logic [SAMPLE_W-1:0] pk_next;
    logic [OUT_W-1:0]    nv;

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned; a missing default would infer a latch.
    always_comb begin
        sample_take = dsp.dsp_ready && !dsp_ready_q;

        // Two's complement negation; the most negative code maps onto itself,
        // which read as unsigned is exactly 2^(SAMPLE_W-1).
        mag = dsp.dsp_data;
        if (SIGNED_IN != 0 && dsp.dsp_data[SAMPLE_W-1]) begin
            mag = (~dsp.dsp_data) + {{(SAMPLE_W-1){1'b0}}, 1'b1};
        end

        // A tick empties the window before the same-cycle sample is added,
        // so that sample opens the new window.
        acc_base = window_tick ? '0 : acc;
        cnt_base = window_tick ? '0 : cnt;
        pk_base  = window_tick ? '0 : pk_w;

        acc_sum  = {1'b0, acc_base} + (sample_take ? (ACC_W + 1)'(mag) : '0);
        acc_next = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
        ovf_next = (window_tick ? 1'b0 : ovf_w) | acc_sum[ACC_W];

        cnt_next = cnt_base;
        if (sample_take && cnt_base != '1) begin
            cnt_next = cnt_base + CNT_W'(1);
        end

        pk_next = pk_base;
        if (sample_take && mag > pk_base) begin
            pk_next = mag;
        end

        nv = acc[ACC_W-1 -: OUT_W];
    end

    // Window datapath and published outputs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            dsp_ready_q  <= 1'b0;
            acc          <= '0;
            cnt          <= '0;
            pk_w         <= '0;
            ovf_w        <= 1'b0;
            volume       <= '0;
            peak         <= '0;
            sample_count <= '0;
            overflow     <= 1'b0;
            volume_valid <= 1'b0;
        end else begin
            dsp_ready_q  <= dsp.dsp_ready;
            acc          <= acc_next;
            cnt          <= cnt_next;
            pk_w         <= pk_next;
            ovf_w        <= ovf_next;
            volume_valid <= window_tick;
            if (window_tick) begin
                volume       <= nv;
                peak         <= pk_w;
                sample_count <= cnt;
                overflow     <= ovf_w;
            end
        end
    end

    // Loud hysteresis FSM, advanced once per closed window using the volume
    // being published in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= QUIET;
            run   <= '0;
            loud  <= 1'b0;
        end else if (window_tick) begin
            case (state)
                QUIET: begin
                    if (nv >= THRESH_ON) begin
                        run <= RUN_W'(1);
                        if (LOUD_WINDOWS == 1) begin
                            state <= LOUD;
                            loud  <= 1'b1;
                        end else begin
                            state <= ARMING;
                        end
                    end
                end
                ARMING: begin
                    if (nv >= THRESH_ON) begin
                        run <= run + RUN_W'(1);
                        if (run + RUN_W'(1) == RUN_W'(LOUD_WINDOWS)) begin
                            state <= LOUD;
                            loud  <= 1'b1;
                        end
                    end else begin
                        run   <= '0;
                        state <= QUIET;
                    end
                end
                LOUD: begin
                    if (nv < THRESH_OFF) begin
                        run   <= '0;
                        state <= QUIET;
                        loud  <= 1'b0;
                    end
                end
                default: begin
                    run   <= '0;
                    state <= QUIET;
                    loud  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_huil_volume_window.sv
// Testbench for huil_volume_window. Two instances share one sample bus:
// u_dut (unsigned samples) and s_dut (SIGNED_IN=1).
module tb_huil_volume_window;

    localparam int ACC_MAX = 16383;

    logic clk = 1'b0;
    logic reset;
    logic window_tick;

    huil_volume_window_if #(.SAMPLE_W(8)) dsp_bus ();

    logic [7:0] u_volume, u_peak, u_count;
    logic       u_overflow, u_valid, u_loud;
    logic [7:0] s_volume, s_peak, s_count;
    logic       s_overflow, s_valid, s_loud;

    huil_volume_window #(.SIGNED_IN(0)) u_dut (
        .clk(clk), .reset(reset), .window_tick(window_tick), .dsp(dsp_bus),
        .volume(u_volume), .peak(u_peak), .sample_count(u_count),
        .overflow(u_overflow), .volume_valid(u_valid), .loud(u_loud)
    );

    huil_volume_window #(.SIGNED_IN(1)) s_dut (
        .clk(clk), .reset(reset), .window_tick(window_tick), .dsp(dsp_bus),
        .volume(s_volume), .peak(s_peak), .sample_count(s_count),
        .overflow(s_overflow), .volume_valid(s_valid), .loud(s_loud)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- stimulus helpers (drive on negedge) ----------------
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; window_tick = 1'b0; dsp_bus.dsp_ready = 1'b0; dsp_bus.dsp_data = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] d);
        @(negedge clk);
        dsp_bus.dsp_ready = 1'b1; dsp_bus.dsp_data = d;
        @(negedge clk);
        dsp_bus.dsp_ready = 1'b0;
    endtask

    task automatic pulses(input int n, input logic [7:0] d);
        for (int i = 0; i < n; i++) pulse(d);
    endtask

    // Close a window and check the unsigned instance; volume_valid must be a
    // single-cycle pulse.
    task automatic tick_check(input string pfx, input logic [7:0] vol, input logic [7:0] pk,
                              input logic [7:0] cnt, input logic ovf, input logic ld);
        @(negedge clk);
        window_tick = 1'b1;
        @(negedge clk);
        window_tick = 1'b0;
        check({pfx, ".valid"}, u_valid, 1'b1);
        check({pfx, ".volume"}, u_volume, vol);
        check({pfx, ".peak"}, u_peak, pk);
        check({pfx, ".count"}, u_count, cnt);
        check({pfx, ".overflow"}, u_overflow, ovf);
        check({pfx, ".loud"}, u_loud, ld);
        @(negedge clk);
        check({pfx, ".valid_low"}, u_valid, 1'b0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        int         n;
        logic [7:0] d;
        logic [7:0] vol;
        logic [7:0] pk;
        logic [7:0] cnt;
        logic       ovf;
        logic       ld;
    } vec_t;

    vec_t vecs[11];

    // ---------------- reference model ----------------
    int  m_sum[2], m_cnt[2], m_pk[2], m_run[2];
    bit  m_loud[2];
    int  e_vol[2], e_pk[2], e_cnt[2];
    bit  e_ovf[2], e_valid, m_prev_ready;

    function automatic int mag_of(input int m, input logic [7:0] d);
        if (m == 1 && d[7]) return 256 - int'(d);
        return int'(d);
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_sum[m] = 0; m_cnt[m] = 0; m_pk[m] = 0; m_run[m] = 0; m_loud[m] = 0;
            e_vol[m] = 0; e_pk[m] = 0; e_cnt[m] = 0; e_ovf[m] = 0;
        end
        e_valid = 0; m_prev_ready = 0;
    endtask

    // One clock edge with the given inputs.
    task automatic model_step(input bit rdy, input logic [7:0] d, input bit tk);
        bit take;
        take = rdy && !m_prev_ready;
        m_prev_ready = rdy;
        e_valid = tk;
        for (int m = 0; m < 2; m++) begin
            if (tk) begin
                int clamped;
                clamped  = (m_sum[m] > ACC_MAX) ? ACC_MAX : m_sum[m];
                e_vol[m] = clamped / 64;
                e_pk[m]  = m_pk[m];
                e_cnt[m] = (m_cnt[m] > 255) ? 255 : m_cnt[m];
                e_ovf[m] = (m_sum[m] > ACC_MAX);
                if (!m_loud[m]) begin
                    m_run[m] = (e_vol[m] >= 'h40) ? m_run[m] + 1 : 0;
                    if (m_run[m] >= 3) m_loud[m] = 1;
                end else if (e_vol[m] < 'h20) begin
                    m_loud[m] = 0;
                    m_run[m]  = 0;
                end
                m_sum[m] = 0; m_cnt[m] = 0; m_pk[m] = 0;
            end
            if (take) begin
                int mg;
                mg = mag_of(m, d);
                m_sum[m] += mg;
                m_cnt[m] += 1;
                if (mg > m_pk[m]) m_pk[m] = mg;
            end
        end
    endtask

    initial begin
        int hold;
        bit rdy, tk;
        logic [7:0] d;

        // volume = acc/64; 40x0x80 -> 0x50, 8x -> 0x10, 24x -> 0x30, 31x0x40 -> 0x1F
        vecs[0]  = '{64,  8'h80, 8'h80, 8'h80, 8'd64,  1'b0, 1'b0};
        vecs[1]  = '{128, 8'hFF, 8'hFF, 8'hFF, 8'd128, 1'b1, 1'b0};
        vecs[2]  = '{1,   8'h01, 8'h00, 8'h01, 8'd1,   1'b0, 1'b0};
        vecs[3]  = '{40,  8'h80, 8'h50, 8'h80, 8'd40,  1'b0, 1'b0};
        vecs[4]  = '{40,  8'h80, 8'h50, 8'h80, 8'd40,  1'b0, 1'b0};
        vecs[5]  = '{8,   8'h80, 8'h10, 8'h80, 8'd8,   1'b0, 1'b0};
        vecs[6]  = '{40,  8'h80, 8'h50, 8'h80, 8'd40,  1'b0, 1'b0};
        vecs[7]  = '{40,  8'h80, 8'h50, 8'h80, 8'd40,  1'b0, 1'b0};
        vecs[8]  = '{40,  8'h80, 8'h50, 8'h80, 8'd40,  1'b0, 1'b1};
        vecs[9]  = '{24,  8'h80, 8'h30, 8'h80, 8'd24,  1'b0, 1'b1};
        vecs[10] = '{31,  8'h40, 8'h1F, 8'h40, 8'd31,  1'b0, 1'b0};

        reset = 1'b1; window_tick = 1'b0; dsp_bus.dsp_ready = 1'b0; dsp_bus.dsp_data = '0;
        do_reset();
        @(negedge clk);
        check("reset.volume", u_volume, 0);
        check("reset.peak", u_peak, 0);
        check("reset.count", u_count, 0);
        check("reset.overflow", u_overflow, 0);
        check("reset.valid", u_valid, 0);
        check("reset.loud", u_loud, 0);
        check("reset.s_volume", s_volume, 0);
        check("reset.s_loud", s_loud, 0);

        for (int i = 0; i < 11; i++) begin
            pulses(vecs[i].n, vecs[i].d);
            tick_check($sformatf("vec%0d", i), vecs[i].vol, vecs[i].pk, vecs[i].cnt,
                       vecs[i].ovf, vecs[i].ld);
        end

        // Held-high ready yields a single sample.
        @(negedge clk);
        dsp_bus.dsp_ready = 1'b1; dsp_bus.dsp_data = 8'h10;
        repeat (20) @(negedge clk);
        dsp_bus.dsp_ready = 1'b0;
        tick_check("held", 8'h00, 8'h10, 8'd1, 1'b0, 1'b0);

        // Sample coinciding with a tick belongs to the new window.
        pulses(2, 8'h08);
        @(negedge clk);
        dsp_bus.dsp_ready = 1'b1; dsp_bus.dsp_data = 8'h40; window_tick = 1'b1;
        @(negedge clk);
        dsp_bus.dsp_ready = 1'b0; window_tick = 1'b0;
        check("coll.count", u_count, 2);
        check("coll.peak", u_peak, 8'h08);
        check("coll.volume", u_volume, 0);

        // Tick held for three cycles closes three windows.
        @(negedge clk);
        window_tick = 1'b1;
        @(negedge clk);
        check("multi1.valid", u_valid, 1);
        check("multi1.count", u_count, 1);
        check("multi1.peak", u_peak, 8'h40);
        check("multi1.volume", u_volume, 1);
        @(negedge clk);
        check("multi2.valid", u_valid, 1);
        check("multi2.count", u_count, 0);
        check("multi2.peak", u_peak, 0);
        @(negedge clk);
        window_tick = 1'b0;
        check("multi3.valid", u_valid, 1);
        check("multi3.volume", u_volume, 0);
        @(negedge clk);
        check("multi.valid_low", u_valid, 0);

        // Signed magnitudes, most negative code included.
        pulse(8'h80); pulse(8'h7F); pulse(8'hFF);
        tick_check("signed.u", 8'h07, 8'hFF, 8'd3, 1'b0, 1'b0);
        @(negedge clk);
        check("signed.s_volume", s_volume, 8'h04);
        check("signed.s_peak", s_peak, 8'h80);
        check("signed.s_count", s_count, 3);

        // Reach LOUD, then reset.
        for (int i = 0; i < 3; i++) begin
            pulses(40, 8'h80);
            tick_check($sformatf("arm%0d", i), 8'h50, 8'h80, 8'd40, 1'b0, (i == 2));
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_loud.loud", u_loud, 0);
        check("rst_loud.volume", u_volume, 0);

        // Reset beats a same-cycle tick.
        @(negedge clk);
        reset = 1'b1; window_tick = 1'b1;
        @(negedge clk);
        reset = 1'b0; window_tick = 1'b0;
        check("rst_tick.valid", u_valid, 0);

        // Reset mid-window discards the partial window.
        pulse(8'h40);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tick_check("rst_mid", 8'h00, 8'h00, 8'd0, 1'b0, 1'b0);

        // Randomized run against the reference model, both instances.
        do_reset();
        model_reset();
        hold = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rdy = 1'($urandom_range(0, 1));
            d   = 8'($urandom);
            if (hold > 0) begin
                tk = 1; hold--;
            end else if ($urandom_range(0, 47) == 0) begin
                tk = 1; hold = $urandom_range(0, 2);
            end else begin
                tk = 0;
            end
            dsp_bus.dsp_ready = rdy; dsp_bus.dsp_data = d; window_tick = tk;
            model_step(rdy, d, tk);
            @(negedge clk);
            check("rnd.u_valid", u_valid, e_valid);
            check("rnd.u_volume", u_volume, e_vol[0]);
            check("rnd.u_peak", u_peak, e_pk[0]);
            check("rnd.u_count", u_count, e_cnt[0]);
            check("rnd.u_overflow", u_overflow, e_ovf[0]);
            check("rnd.u_loud", u_loud, m_loud[0]);
            check("rnd.s_valid", s_valid, e_valid);
            check("rnd.s_volume", s_volume, e_vol[1]);
            check("rnd.s_peak", s_peak, e_pk[1]);
            check("rnd.s_count", s_count, e_cnt[1]);
            check("rnd.s_overflow", s_overflow, e_ovf[1]);
            check("rnd.s_loud", s_loud, m_loud[1]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
